// File: rtl/fifo_da.sv
// fifo_da: single-clock first-word-fall-through FIFO; head on o_data_out the cycle after its write edge, registered flags.
// Writes while full are dropped, reads while empty ignored; define FIFO_DA_ASSERT_EN for simulation overflow/underflow checks.
module fifo_da #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_write_en,
  output logic             i_full_out,
  output logic [WIDTH-1:0] o_data_out,
  input  logic             o_read_en,
  output logic             o_empty_out
);

  localparam int ADDRESS_WIDTH = $clog2(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE  = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE  = (ADDRESS_WIDTH + 1)'(1);
  localparam logic [ADDRESS_WIDTH:0]   CNT_FULL = (ADDRESS_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0]         r_mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
  logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
  logic [ADDRESS_WIDTH:0]   r_count;
  logic                     r_full;
  logic                     r_empty;

  logic                     w_wr_ok;
  logic                     w_rd_ok;
  logic [ADDRESS_WIDTH:0]   w_count_nxt;

  // Accepts gate on the flags of the current cycle, so a full FIFO rejects a
  // concurrent write and an empty one ignores a concurrent read.
  assign w_wr_ok = i_write_en & ~r_full;
  assign w_rd_ok = o_read_en & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
    end else if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= i_data_in;
      r_wr_ptr        <= r_wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_data_out  = r_mem[r_rd_ptr];
  assign i_full_out  = r_full;
  assign o_empty_out = r_empty;

`ifdef FIFO_DA_ASSERT_EN
  always @(posedge clk) begin
    if (clear && i_write_en && r_full) begin
      $display("FIFO_DA OVERFLOW");
      $stop;
    end
    if (clear && o_read_en && r_empty) begin
      $display("FIFO_DA UNDERFLOW");
      $stop;
    end
  end
`else
  // Overflow and underflow fall back to the silent drop/ignore behaviour above.
`endif

endmodule

// File: tb/tb_fifo_da.sv
// Directed bench for fifo_da (WIDTH=2, DEPTH=32) with a queue scoreboard and a model occupancy count.
module tb_fifo_da;

  localparam int W = 2;
  localparam int D = 32;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic [W-1:0] i_data_in = '0;
  logic         i_write_en = 1'b0;
  logic         i_full_out;
  logic [W-1:0] o_data_out;
  logic         o_read_en = 1'b0;
  logic         o_empty_out;

  int           passed = 0;
  int           total = 0;
  int           cnt = 0;
  logic [W-1:0] exp_q [$];

  fifo_da #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .clear       (clear),
    .i_data_in   (i_data_in),
    .i_write_en  (i_write_en),
    .i_full_out  (i_full_out),
    .o_data_out  (o_data_out),
    .o_read_en   (o_read_en),
    .o_empty_out (o_empty_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    check({tag, " empty"}, {31'b0, o_empty_out}, {31'b0, cnt == 0});
    check({tag, " full"},  {31'b0, i_full_out},  {31'b0, cnt == D});
    if (exp_q.size() > 0) check({tag, " head"}, {30'b0, o_data_out}, {30'b0, exp_q[0]});
  endtask

  // One clock cycle of stimulus; called #1 after a rising edge.
  task automatic step(input logic wr, input logic [W-1:0] d, input logic rd, input string tag);
    logic wr_ok, rd_ok;
    wr_ok = wr && (cnt != D);
    rd_ok = rd && (cnt != 0);
    i_write_en = wr;
    i_data_in  = d;
    o_read_en  = rd;
    if (rd_ok) begin
      check({tag, " pop"}, {30'b0, o_data_out}, {30'b0, exp_q[0]});
      void'(exp_q.pop_front());
      cnt--;
    end
    if (wr_ok) begin
      exp_q.push_back(d);
      cnt++;
    end
    @(posedge clk);
    #1;
    i_write_en = 1'b0;
    o_read_en  = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input int cycles);
    clear      = 1'b0;
    i_write_en = 1'b1;
    o_read_en  = 1'b1;
    i_data_in  = 2'b11;
    repeat (cycles) @(posedge clk);
    #1;
    clear      = 1'b1;
    i_write_en = 1'b0;
    o_read_en  = 1'b0;
    exp_q.delete();
    cnt = 0;
    check("reset empty", {31'b0, o_empty_out}, 32'd1);
    check("reset full",  {31'b0, i_full_out},  32'd0);
    check("reset data",  {30'b0, o_data_out},  32'd0);
  endtask

  task automatic drain(input string tag);
    while (cnt > 0) step(1'b0, '0, 1'b1, tag);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(2);

    // fall-through: head visible with no read
    step(1'b1, 2'b10, 1'b0, "fwft");
    drain("fwft drain");

    // fill, overflow drop, drain
    for (int i = 0; i < D; i++) step(1'b1, W'(i % 4), 1'b0, "fill");
    check("fill full", {31'b0, i_full_out}, 32'd1);
    step(1'b1, 2'b11, 1'b0, "overflow");
    drain("fill drain");
    check("drain empty", {31'b0, o_empty_out}, 32'd1);

    // simultaneous rd/wr with 5 entries
    for (int i = 0; i < 5; i++) step(1'b1, W'(i), 1'b0, "five");
    for (int i = 0; i < 10; i++) step(1'b1, W'($urandom), 1'b1, "rw5");
    check("rw5 count", cnt, 32'd5);
    drain("rw5 drain");

    // simultaneous rd/wr while full
    for (int i = 0; i < D; i++) step(1'b1, W'($urandom), 1'b0, "refill");
    step(1'b1, 2'b01, 1'b1, "rw full");
    check("rw full flag", {31'b0, i_full_out}, 32'd0);
    check("rw full count", cnt, 32'd31);
    drain("rw full drain");

    // wrap-around with occupancy 1..3
    for (int i = 0; i < 100; i++)
      step(1'b1, W'($urandom), (cnt == 3) || (cnt >= 1 && $urandom_range(1) == 1), "wrap");
    drain("wrap drain");

    // read while empty, then confirm pointers still aligned
    step(1'b0, '0, 1'b1, "empty rd");
    step(1'b1, 2'b01, 1'b0, "after empty rd");
    drain("after empty rd drain");

    // mid-operation reset with 7 entries
    for (int i = 0; i < 7; i++) step(1'b1, W'(i + 1), 1'b0, "seven");
    do_reset(1);
    step(1'b1, 2'b11, 1'b0, "post reset");
    step(1'b1, 2'b10, 1'b1, "post reset rw");
    drain("post reset drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
